// File: rtl/dma_mem_arb_if.sv
// -----------------------------------------------------------------------------
// dma_mem_arb_if
//   Bundles every bus signal around the DMA/Wishbone memory arbiter:
//   - WB side   : wb_addr, wb_data_i, wb_we, wb_en  -> arbiter
//                 wb_data_o, wb_ack                 <- arbiter
//   - DMA side  : dma_addr, dma_data_i, dma_we, dma_en -> arbiter (channel i
//                 occupies slice i of each packed vector)
//                 dma_grant, dma_data_o, dma_read_ack  <- arbiter
//   - Memory    : mem_stb, mem_we, mem_sel, mem_addr, mem_wdata <- arbiter
//                 mem_rdata                                     -> arbiter
//   Modports:
//   - slave  : the arbiter itself (serves WB/DMA requesters, drives memory)
//   - master : the surrounding system (requesters plus the memory model)
// -----------------------------------------------------------------------------
interface dma_mem_arb_if #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int NCH = 2
) ();

  // Wishbone requester
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data_i;
  logic [DW/8-1:0]   wb_we;
  logic              wb_en;
  logic [DW-1:0]     wb_data_o;
  logic              wb_ack;

  // DMA channels
  logic [NCH*AW-1:0] dma_addr;
  logic [NCH*DW-1:0] dma_data_i;
  logic [NCH-1:0]    dma_we;
  logic [NCH-1:0]    dma_en;
  logic [NCH-1:0]    dma_grant;
  logic [DW-1:0]     dma_data_o;
  logic [NCH-1:0]    dma_read_ack;

  // Memory command / return
  logic              mem_stb;
  logic              mem_we;
  logic [DW/8-1:0]   mem_sel;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  wb_addr, wb_data_i, wb_we, wb_en,
    output wb_data_o, wb_ack,
    input  dma_addr, dma_data_i, dma_we, dma_en,
    output dma_grant, dma_data_o, dma_read_ack,
    output mem_stb, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wb_addr, wb_data_i, wb_we, wb_en,
    input  wb_data_o, wb_ack,
    output dma_addr, dma_data_i, dma_we, dma_en,
    input  dma_grant, dma_data_o, dma_read_ack,
    input  mem_stb, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : dma_mem_arb_if

// File: rtl/dma_mem_arb.sv
// -----------------------------------------------------------------------------
// dma_mem_arb
//   Arbitrates one fully pipelined memory port between a Wishbone requester
//   and NCH DMA channels. At most one command issues per cycle; mem_stb marks
//   exactly the grant cycles.
//
//   Priority each cycle (purely combinational on current requests):
//     1. WB, if eligible and it has waited WB_MAX_WAIT cycles (starvation)
//     2. DMA channels, round-robin starting at the RR pointer
//     3. WB, if eligible
//   WB is eligible when wb_en=1 and no WB read is outstanding.
//
//   Reads are tracked by an RD_LAT-deep tag pipeline of {valid, source id};
//   id NCH means WB. When a tag leaves the pipeline the matching ack pulses
//   and mem_rdata is presented on both read-data outputs.
//
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low reset; also gates all grants
//     bus    - dma_mem_arb_if.slave (WB, DMA and memory signals)
// -----------------------------------------------------------------------------
module dma_mem_arb #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int NCH         = 2,
  parameter int RD_LAT      = 10,
  parameter int WB_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_mem_arb_if.slave  bus
);

  localparam int SW  = DW / 8;
  localparam int IDW = $clog2(NCH + 1);
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(WB_MAX_WAIT + 1);

  localparam logic [IDW-1:0] WB_ID    = IDW'(NCH);
  localparam logic [CW-1:0]  STARVE_MAX = CW'(WB_MAX_WAIT);

  // WB read tracking: a single read may be in flight at a time.
  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_RD_PEND = 1'b1
  } wb_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_state_e         wb_state_q, wb_state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]    tag_id_q [RD_LAT];
  logic [IDW-1:0]    tag_id_d [RD_LAT];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic          dma_hit;
  logic [PW-1:0] dma_idx;
  logic [PW-1:0] cand;
  logic          wb_elig;
  logic          wb_urgent;
  logic          wb_is_rd;
  logic          grant_wb;
  logic          grant_dma;

  // Round-robin search: the first asserted request at or after rr_q wins.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch;
    // a path that leaves one unassigned would infer a latch.
    dma_hit = 1'b0;
    dma_idx = '0;
    cand    = '0;
    for (int off = 0; off < NCH; off++) begin
      cand = PW'((int'(rr_q) + off) % NCH);
      if (!dma_hit && bus.dma_en[cand]) begin
        dma_hit = 1'b1;
        dma_idx = cand;
      end
    end
  end

  assign wb_elig   = bus.wb_en && (wb_state_q == WB_IDLE);
  assign wb_urgent = wb_elig && (starve_q == STARVE_MAX);
  assign wb_is_rd  = (bus.wb_we == '0);

  // Reset gates the grants so nothing issues while rst_n is low, even if
  // requesters keep their enables asserted.
  assign grant_wb  = rst_n && (wb_urgent || (wb_elig && !dma_hit));
  assign grant_dma = rst_n && !wb_urgent && dma_hit;

  // ---------------------------------------------------------------------------
  // Memory command and grant outputs
  // ---------------------------------------------------------------------------
  logic           push_v;
  logic [IDW-1:0] push_id;

  always_comb begin
    bus.mem_stb   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_sel   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.dma_grant = '0;
    push_v        = 1'b0;
    push_id       = '0;

    if (grant_dma) begin
      bus.dma_grant[dma_idx] = 1'b1;
      bus.mem_stb            = 1'b1;
      bus.mem_we             = bus.dma_we[dma_idx];
      bus.mem_sel            = '1;
      bus.mem_addr           = bus.dma_addr[int'(dma_idx)*AW +: AW];
      bus.mem_wdata          = bus.dma_data_i[int'(dma_idx)*DW +: DW];
      push_v                 = !bus.dma_we[dma_idx];
      push_id                = IDW'(dma_idx);
    end else if (grant_wb) begin
      bus.mem_stb   = 1'b1;
      bus.mem_we    = |bus.wb_we;
      // A WB read has no byte enables of its own; fetch the whole word.
      bus.mem_sel   = wb_is_rd ? {SW{1'b1}} : bus.wb_we;
      bus.mem_addr  = bus.wb_addr;
      bus.mem_wdata = bus.wb_data_i;
      push_v        = wb_is_rd;
      push_id       = WB_ID;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  logic           ret_v;
  logic [IDW-1:0] ret_id;
  logic           wb_ret;

  assign ret_v  = tag_v_q[RD_LAT-1];
  assign ret_id = tag_id_q[RD_LAT-1];
  assign wb_ret = ret_v && (ret_id == WB_ID);

  // Writes complete at issue; reads complete when their tag emerges.
  assign bus.wb_ack     = (grant_wb && !wb_is_rd) || wb_ret;
  assign bus.wb_data_o  = bus.mem_rdata;
  assign bus.dma_data_o = bus.mem_rdata;

  always_comb begin
    bus.dma_read_ack = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.dma_read_ack[i] = ret_v && (ret_id == IDW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_state_d = wb_state_q;
    case (wb_state_q)
      WB_IDLE:    if (grant_wb && wb_is_rd) wb_state_d = WB_RD_PEND;
      WB_RD_PEND: if (wb_ret)               wb_state_d = WB_IDLE;
      default:                              wb_state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_dma) begin
      rr_d = (dma_idx == PW'(NCH - 1)) ? '0 : dma_idx + 1'b1;
    end
  end

  // The counter only moves while WB is eligible and losing; while a WB read
  // is outstanding it simply holds.
  always_comb begin
    starve_d = starve_q;
    if (!bus.wb_en || grant_wb) begin
      starve_d = '0;
    end else if (wb_elig && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Tag pipeline advances every cycle; stage 0 captures this cycle's read.
  always_comb begin
    tag_v_d     = '0;
    tag_v_d[0]  = push_v;
    tag_id_d[0] = push_id;
    for (int s = 1; s < RD_LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_state_q <= WB_IDLE;
      rr_q       <= '0;
      starve_q   <= '0;
      tag_v_q    <= '0;
    end else begin
      wb_state_q <= wb_state_d;
      rr_q       <= rr_d;
      starve_q   <= starve_d;
      tag_v_q    <= tag_v_d;
    end
  end

  // NOTE: the id payload has no reset; clearing the valid bits is enough to
  // discard in-flight reads, and leaving the ids unreset keeps them plain
  // flops without a reset net.
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
  end

endmodule : dma_mem_arb

// File: tb/tb_dma_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_dma_mem_arb
//   Directed stimulus for dma_mem_arb (DW=32, AW=32, NCH=2, RD_LAT=10,
//   WB_MAX_WAIT=4). Stimulus pushes expected grant/ack events with their
//   absolute cycle into a queue; a monitor on the falling edge pops matching
//   entries for every grant/ack the DUT shows, and flags anything unexpected
//   or overdue. A small memory model returns read data RD_LAT cycles after a
//   read command.
// -----------------------------------------------------------------------------
module tb_dma_mem_arb;

  localparam int DW          = 32;
  localparam int AW          = 32;
  localparam int NCH         = 2;
  localparam int RD_LAT      = 10;
  localparam int WB_MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_mem_arb_if #(.DW(DW), .AW(AW), .NCH(NCH)) bus ();

  dma_mem_arb #(
    .DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(RD_LAT), .WB_MAX_WAIT(WB_MAX_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef enum {EV_DGRANT, EV_WGRANT, EV_DRACK, EV_WACK} ev_kind_e;

  typedef struct {
    int              cyc;
    ev_kind_e        kind;
    int              id;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   rdata;
    bit              chk_rdata;
  } ev_t;

  ev_t exp_q[$];
  int  nchk = 0;
  int  nerr = 0;
  int  cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Memory model: read data is a fixed function of the address.
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 32'hDEAD_BEEF ^ (a ^ 32'h0000_0040);
  endfunction

  logic [DW-1:0] mem_buf [64];
  initial for (int i = 0; i < 64; i++) mem_buf[i] = '0;

  always @(negedge clk) begin
    if (bus.mem_stb === 1'b1 && bus.mem_we === 1'b0)
      mem_buf[(cyc + RD_LAT) % 64] = mem_f(bus.mem_addr);
  end
  assign bus.mem_rdata = mem_buf[cyc % 64];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input ev_kind_e k, input int id);
    int  idx;
    ev_t e;
    idx = -1;
    foreach (exp_q[j]) if (idx < 0 && exp_q[j].kind == k && exp_q[j].cyc == cyc) idx = j;
    if (idx < 0) begin
      nchk++;
      nerr++;
      $display("FAIL unexpected_%s: got id %0d at cycle %0d, required none", k.name(), id, cyc);
      return;
    end
    e = exp_q[idx];
    exp_q.delete(idx);
    check($sformatf("%s_id", k.name()), 64'(id), 64'(e.id));
    if (k == EV_DGRANT || k == EV_WGRANT) begin
      check($sformatf("%s_addr", k.name()),  64'(bus.mem_addr),  64'(e.addr));
      check($sformatf("%s_wdata", k.name()), 64'(bus.mem_wdata), 64'(e.wdata));
      check($sformatf("%s_we", k.name()),    64'(bus.mem_we),    64'(e.we));
      check($sformatf("%s_sel", k.name()),   64'(bus.mem_sel),   64'(e.sel));
    end else if (e.chk_rdata) begin
      if (k == EV_DRACK) check("dma_data_o", 64'(bus.dma_data_o), 64'(e.rdata));
      else               check("wb_data_o",  64'(bus.wb_data_o),  64'(e.rdata));
    end
  endtask

  always @(negedge clk) begin
    int gi;
    if (bus.mem_stb === 1'b1) begin
      if (bus.dma_grant === '0) begin
        observe(EV_WGRANT, NCH);
      end else if ($onehot(bus.dma_grant)) begin
        gi = 0;
        for (int i = 0; i < NCH; i++) if (bus.dma_grant[i]) gi = i;
        observe(EV_DGRANT, gi);
      end else begin
        nchk++;
        nerr++;
        $display("FAIL grant_onehot: got %b, required one-hot (cycle %0d)", bus.dma_grant, cyc);
      end
    end else if (bus.dma_grant !== '0) begin
      nchk++;
      nerr++;
      $display("FAIL grant_without_stb: got grant %b, required 0 (cycle %0d)", bus.dma_grant, cyc);
    end
    for (int i = 0; i < NCH; i++) if (bus.dma_read_ack[i] === 1'b1) observe(EV_DRACK, i);
    if (bus.wb_ack === 1'b1) observe(EV_WACK, NCH);
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].cyc <= cyc) begin
        nchk++;
        nerr++;
        $display("FAIL missing_%s: got nothing at cycle %0d, required id %0d",
                 exp_q[j].kind.name(), exp_q[j].cyc, exp_q[j].id);
        exp_q.delete(j);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Expectation helpers
  // ---------------------------------------------------------------------------
  task automatic exp_grant(input ev_kind_e k, input int c, input int ch, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic we, input logic [DW/8-1:0] sel);
    ev_t e;
    e = '{cyc: c, kind: k, id: ch, addr: a, wdata: d, we: we, sel: sel, rdata: '0, chk_rdata: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic exp_ack(input ev_kind_e k, input int c, input int ch, input bit chk,
                         input logic [DW-1:0] rd);
    ev_t e;
    e = '{cyc: c, kind: k, id: ch, addr: '0, wdata: '0, we: 1'b0, sel: '0, rdata: rd, chk_rdata: chk};
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_addr    = '0;
    bus.wb_data_i  = '0;
    bus.wb_we      = '0;
    bus.wb_en      = 1'b0;
    bus.dma_addr   = '0;
    bus.dma_data_i = '0;
    bus.dma_we     = '0;
    bus.dma_en     = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_stb"},      64'(bus.mem_stb),      64'd0);
    check({tag, "_dma_grant"},    64'(bus.dma_grant),    64'd0);
    check({tag, "_dma_read_ack"}, 64'(bus.dma_read_ack), 64'd0);
    check({tag, "_wb_ack"},       64'(bus.wb_ack),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c;
    int ch;
    int j;

    // Reset with every requester active: nothing may be granted or acked.
    idle();
    rst_n = 1'b0;
    bus.dma_en = 2'b11;
    bus.wb_en  = 1'b1;
    step();
    check_quiet("reset");
    idle();
    step();
    rst_n = 1'b1;
    step();

    // Both channels writing for 4 cycles: grants 01,10,01,10.
    c = cyc;
    bus.dma_en     = 2'b11;
    bus.dma_we     = 2'b11;
    bus.dma_addr   = {32'h0000_0200, 32'h0000_0100};
    bus.dma_data_i = {32'h2222_0000, 32'h1111_0000};
    exp_grant(EV_DGRANT, c,     0, 32'h100, 32'h1111_0000, 1'b1, 4'hF);
    exp_grant(EV_DGRANT, c + 1, 1, 32'h200, 32'h2222_0000, 1'b1, 4'hF);
    exp_grant(EV_DGRANT, c + 2, 0, 32'h100, 32'h1111_0000, 1'b1, 4'hF);
    exp_grant(EV_DGRANT, c + 3, 1, 32'h200, 32'h2222_0000, 1'b1, 4'hF);
    repeat (4) step();
    idle();
    step();

    // Single DMA read ch0 @0x40 -> ack at +10 with 0xDEADBEEF.
    c = cyc;
    bus.dma_en     = 2'b01;
    bus.dma_addr   = {32'h0, 32'h0000_0040};
    bus.dma_data_i = {32'h0, 32'h1234_5678};
    exp_grant(EV_DGRANT, c, 0, 32'h40, 32'h1234_5678, 1'b0, 4'hF);
    exp_ack(EV_DRACK, c + RD_LAT, 0, 1'b1, 32'hDEAD_BEEF);
    step();
    idle();
    repeat (11) step();

    // Back-to-back reads ch0, ch1, ch0 -> acks at +10, +11, +12.
    c = cyc;
    bus.dma_en   = 2'b01;
    bus.dma_addr = {32'h0, 32'h0000_0300};
    exp_grant(EV_DGRANT, c,     0, 32'h300, 32'h0, 1'b0, 4'hF);
    exp_grant(EV_DGRANT, c + 1, 1, 32'h404, 32'h0, 1'b0, 4'hF);
    exp_grant(EV_DGRANT, c + 2, 0, 32'h308, 32'h0, 1'b0, 4'hF);
    exp_ack(EV_DRACK, c + 10, 0, 1'b1, mem_f(32'h300));
    exp_ack(EV_DRACK, c + 11, 1, 1'b1, mem_f(32'h404));
    exp_ack(EV_DRACK, c + 12, 0, 1'b1, mem_f(32'h308));
    step();
    bus.dma_en   = 2'b10;
    bus.dma_addr = {32'h0000_0404, 32'h0};
    step();
    bus.dma_en   = 2'b01;
    bus.dma_addr = {32'h0, 32'h0000_0308};
    step();
    idle();
    repeat (13) step();

    // WB partial write while idle: same-cycle ack, sel=0011, we=1.
    c = cyc;
    bus.wb_en     = 1'b1;
    bus.wb_we     = 4'b0011;
    bus.wb_addr   = 32'h0000_0500;
    bus.wb_data_i = 32'hCAFE_F00D;
    exp_grant(EV_WGRANT, c, NCH, 32'h500, 32'hCAFE_F00D, 1'b1, 4'b0011);
    exp_ack(EV_WACK, c, NCH, 1'b0, '0);
    step();
    idle();
    step();

    // WB read against continuous DMA writes: WB wins on the 5th cycle, acks
    // 10 cycles later, and is not granted again meanwhile. RR pointer is 1.
    c = cyc;
    bus.wb_en      = 1'b1;
    bus.wb_addr    = 32'h0000_0600;
    bus.dma_en     = 2'b11;
    bus.dma_we     = 2'b11;
    bus.dma_addr   = {32'h0000_02A0, 32'h0000_01A0};
    bus.dma_data_i = {32'h0000_000B, 32'h0000_000A};
    for (int i = 0; i < 15; i++) begin
      if (i == WB_MAX_WAIT) begin
        exp_grant(EV_WGRANT, c + i, NCH, 32'h600, 32'h0, 1'b0, 4'hF);
      end else begin
        j  = (i < WB_MAX_WAIT) ? i : i - 1;
        ch = (j % 2 == 0) ? 1 : 0;
        if (ch == 1) exp_grant(EV_DGRANT, c + i, 1, 32'h2A0, 32'h0B, 1'b1, 4'hF);
        else         exp_grant(EV_DGRANT, c + i, 0, 32'h1A0, 32'h0A, 1'b1, 4'hF);
      end
    end
    exp_ack(EV_WACK, c + WB_MAX_WAIT + RD_LAT, NCH, 1'b1, mem_f(32'h600));
    repeat (15) step();
    idle();
    repeat (2) step();

    // Read in flight when reset hits at +5 must never be acknowledged.
    c = cyc;
    bus.dma_en   = 2'b01;
    bus.dma_addr = {32'h0, 32'h0000_0700};
    exp_grant(EV_DGRANT, c, 0, 32'h700, 32'h0, 1'b0, 4'hF);
    step();
    idle();
    repeat (4) step();
    rst_n      = 1'b0;
    bus.dma_en = 2'b11;
    bus.wb_en  = 1'b1;
    #1;
    check_quiet("midreset_a");
    step();
    check_quiet("midreset_b");
    step();
    idle();
    rst_n = 1'b1;
    repeat (3) step();
    check("flushed_dma_read_ack", 64'(bus.dma_read_ack), 64'd0);
    check("flushed_wb_ack",       64'(bus.wb_ack),       64'd0);
    repeat (3) step();

    // WB read from idle, then a DMA read while WB is outstanding: the DMA
    // channel gets through even with wb_en held, both acks arrive on time.
    c = cyc;
    bus.wb_en   = 1'b1;
    bus.wb_addr = 32'h0000_0800;
    exp_grant(EV_WGRANT, c, NCH, 32'h800, 32'h0, 1'b0, 4'hF);
    exp_ack(EV_WACK, c + RD_LAT, NCH, 1'b1, mem_f(32'h800));
    exp_grant(EV_DGRANT, c + 1, 1, 32'h900, 32'h0, 1'b0, 4'hF);
    exp_ack(EV_DRACK, c + 1 + RD_LAT, 1, 1'b1, mem_f(32'h900));
    step();
    bus.dma_en   = 2'b10;
    bus.dma_addr = {32'h0000_0900, 32'h0};
    step();
    bus.dma_en   = '0;
    bus.dma_addr = '0;
    repeat (9) step();
    idle();
    repeat (5) step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule : tb_dma_mem_arb

// File: doc/dma_mem_arb.md
DMA_MEM_ARB -- requirements
Module: dma_mem_arb

Interface
REQ-001 Parameter DW, default 32: data width; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter NCH, default 2: number of DMA channels; legal range 1..8.
REQ-004 Parameter RD_LAT, default 10: memory read latency in cycles from issue to data valid; legal range >= 1.
REQ-005 Parameter WB_MAX_WAIT, default 4: WB starvation limit in cycles; legal range >= 1.
REQ-006 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_addr  in  AW  WB address
- wb_data_i  in  DW  WB write data
- wb_we  in  DW/8  WB byte write enables; all zero means read
- wb_en  in  1  WB request; held high until wb_ack
- wb_data_o  out  DW  WB read data
- wb_ack  out  1  WB completion pulse
- dma_addr  in  NCH*AW  per-channel address, channel i at slice i
- dma_data_i  in  NCH*DW  per-channel write data
- dma_we  in  NCH  per-channel write(1)/read(0)
- dma_en  in  NCH  per-channel request; held until dma_grant[i]
- dma_grant  out  NCH  one-hot; request accepted this cycle
- dma_data_o  out  DW  DMA read data, shared
- dma_read_ack  out  NCH  per-channel read-data-valid pulse
- mem_stb  out  1  memory command strobe
- mem_we  out  1  memory write(1)/read(0)
- mem_sel  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after a read issue

Function
REQ-008 The block SHALL issue at most one command per cycle; the memory accepts a command every cycle (fully pipelined), and mem_stb SHALL be 1 exactly in cycles where a grant is made.
REQ-009 Arbitration SHALL be combinational on current requests, in this priority order:
- (a) WB, when wb_en=1, no WB read is outstanding, and the starvation counter equals WB_MAX_WAIT
- (b) round-robin among asserted dma_en bits, starting from the RR pointer
- (c) WB, when wb_en=1 and no WB read is outstanding
REQ-010 After a DMA grant to channel k, the RR pointer SHALL become (k+1) mod NCH; it SHALL be unchanged in all other cycles.
REQ-011 The starvation counter SHALL increment, saturating at WB_MAX_WAIT, in each cycle where wb_en=1, no WB read is outstanding, and WB is not granted; it SHALL clear on a WB grant or when wb_en=0.
REQ-012 DMA grant: dma_grant[i]=1 in the issue cycle, with mem_addr, mem_wdata and mem_we taken from slice i, and mem_sel all ones.
REQ-013 WB grant: mem_addr, mem_wdata and mem_sel=wb_we, with mem_we=|wb_we; for a WB read, mem_sel SHALL be all ones.
REQ-014 A WB write SHALL raise wb_ack combinationally in its grant cycle.
REQ-015 A WB read SHALL set an outstanding flag; wb_ack SHALL pulse 1 cycle exactly RD_LAT cycles after the grant, with wb_data_o=mem_rdata in that cycle; the flag SHALL clear in that cycle.
REQ-016 A DMA read SHALL pulse dma_read_ack[i] exactly RD_LAT cycles after its grant, with dma_data_o=mem_rdata in that cycle; any number of DMA reads may be outstanding.
REQ-017 Read returns SHALL be tracked by an RD_LAT-stage shift register of {valid, source id}, with source id width clog2(NCH+1) and id NCH denoting WB; the pipeline SHALL advance every cycle.
REQ-018 A DMA write SHALL produce no acknowledgement beyond dma_grant.
REQ-019 Simultaneous wb_en and all dma_en asserted: WB SHALL be granted no later than WB_MAX_WAIT+1 cycles after it becomes eligible.
REQ-020 dma_data_o and wb_data_o SHALL both drive mem_rdata; only the ack qualifies them.

Reset
REQ-021 While rst_n=0, asynchronously: RR pointer=0, starvation counter=0, WB outstanding flag=0, all tag-pipeline valid bits=0.
REQ-022 Consequently, while rst_n=0: wb_ack=0, dma_read_ack=0, and dma_grant=0 and mem_stb=0 (grants are also gated by rst_n).
REQ-023 Reads in flight when reset asserts SHALL be discarded and never acknowledged after reset releases.

Verification
REQ-024 dma_en=2'b01, read, addr 0x40, mem_rdata=0xDEADBEEF at return -> grant cycle 0, dma_read_ack=2'b01 at cycle 10 only, dma_data_o=0xDEADBEEF.
REQ-025 dma_en=2'b11 held for 4 cycles -> dma_grant sequence 01,10,01,10.
REQ-026 wb_en=1 read with dma_en=2'b11 continuous -> WB granted on the 5th cycle, wb_ack at grant+10, no second WB grant before the ack.
REQ-027 WB write with wb_we=4'b0011 while idle -> same-cycle wb_ack=1, mem_sel=4'b0011, mem_we=1.
REQ-028 Back-to-back DMA reads on cycles 0,1,2 (ch0, ch1, ch0) -> dma_read_ack pulses at cycles 10, 11, 12 on ch0, ch1, ch0.
REQ-029 rst_n low at cycle 5 after a read granted at cycle 0 -> no ack at cycle 10; all outputs 0 during reset.
